clock_adjust_ctrl: RTL and testbench

//  Adjust-mode sequencer for the century clock. Turns three debounced push-buttons (MODE/UP/DOWN)

---
 rtl/clock_adjust_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_clock_adjust_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_adjust_ctrl.sv
// ----------------------------------------------------------------------------
// clock_adjust_ctrl
//   Adjust-mode sequencer for the century clock. Converts three debounced
//   push-button levels (MODE/UP/DOWN) into a one-hot field enable plus
//   single-cycle increment/decrement pulses, with hold-to-repeat, an
//   inactivity timeout back to run mode, and a blink phase for the display.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   btn_mode   in   MODE level (async to clk), active-high
//   btn_up     in   UP level (async to clk), active-high
//   btn_down   in   DOWN level (async to clk), active-high
//   adj_en     out  one-hot field enable [0]sec..[5]year, 0 in RUN
//   adj_up     out  one-cycle increment pulse for the enabled field
//   adj_down   out  one-cycle decrement pulse for the enabled field
//   adj_active out  high in any adjust state
//   blink      out  display blink phase, 0 in RUN
// ----------------------------------------------------------------------------
module clock_adjust_ctrl #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT       = 500_000_000,
  parameter int BLINK_HALF    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] adj_en,
  output logic       adj_up,
  output logic       adj_down,
  output logic       adj_active,
  output logic       blink
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [HW-1:0] HOLD_DELAY  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_PERIOD = HW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_SEC  = 3'd1,
    S_MIN  = 3'd2,
    S_HOUR = 3'd3,
    S_DAY  = 3'd4,
    S_MON  = 3'd5,
    S_YEAR = 3'd6
  } state_t;

  function automatic state_t next_field(input state_t s);
    case (s)
      S_RUN:   next_field = S_SEC;
      S_SEC:   next_field = S_MIN;
      S_MIN:   next_field = S_HOUR;
      S_HOUR:  next_field = S_DAY;
      S_DAY:   next_field = S_MON;
      S_MON:   next_field = S_YEAR;
      default: next_field = S_RUN;
    endcase
  endfunction

  function automatic logic [5:0] field_en(input state_t s);
    case (s)
      S_SEC:   field_en = 6'b000001;
      S_MIN:   field_en = 6'b000010;
      S_HOUR:  field_en = 6'b000100;
      S_DAY:   field_en = 6'b001000;
      S_MON:   field_en = 6'b010000;
      S_YEAR:  field_en = 6'b100000;
      default: field_en = 6'b000000;
    endcase
  endfunction

  // Saturating increment: terminal counts are compared exactly, so a counter
  // must never wrap past its limit even if the terminal branch is missed.
  function automatic logic [TW-1:0] sat_inc_to(input logic [TW-1:0] v);
    sat_inc_to = (v == TO_LAST) ? v : v + TW'(1);
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;

  // p0/p1: two-flop synchronizer; p2: previous synced level for rise detect
  logic          r_mode_p0, r_mode_p1, r_mode_p2;
  logic          r_up_p0,   r_up_p1,   r_up_p2;
  logic          r_dn_p0,   r_dn_p1,   r_dn_p2;

  logic [HW-1:0] r_hold;
  logic          r_armed;
  logic          r_dir_up;
  logic          r_rep;
  logic [TW-1:0] r_to;
  logic [BW-1:0] r_blink_cnt;

  logic [5:0]    r_adj_en;
  logic          r_adj_up, r_adj_down, r_adj_active, r_blink;

  logic          w_mode_rise, w_up_rise, w_dn_rise, w_any_rise;
  logic          w_in_adj, w_state_chg;
  logic          w_alone_up, w_alone_dn;
  logic          w_hold_term, w_hold_keep;
  logic          w_arm_up, w_arm_dn, w_rep_fire;
  logic          w_step_up, w_step_dn;

  // ---- stage p0..p2: synchronizers and rise detectors ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_p0 <= 1'b0; r_mode_p1 <= 1'b0; r_mode_p2 <= 1'b0;
      r_up_p0   <= 1'b0; r_up_p1   <= 1'b0; r_up_p2   <= 1'b0;
      r_dn_p0   <= 1'b0; r_dn_p1   <= 1'b0; r_dn_p2   <= 1'b0;
    end else begin
      r_mode_p0 <= btn_mode; r_mode_p1 <= r_mode_p0; r_mode_p2 <= r_mode_p1;
      r_up_p0   <= btn_up;   r_up_p1   <= r_up_p0;   r_up_p2   <= r_up_p1;
      r_dn_p0   <= btn_down; r_dn_p1   <= r_dn_p0;   r_dn_p2   <= r_dn_p1;
    end
  end

  assign w_mode_rise = r_mode_p1 & ~r_mode_p2;
  assign w_up_rise   = r_up_p1   & ~r_up_p2;
  assign w_dn_rise   = r_dn_p1   & ~r_dn_p2;
  assign w_any_rise  = w_mode_rise | w_up_rise | w_dn_rise;
  assign w_alone_up  = r_up_p1 & ~r_dn_p1;
  assign w_alone_dn  = r_dn_p1 & ~r_up_p1;
  assign w_hold_term = r_rep ? (r_hold == HOLD_PERIOD) : (r_hold == HOLD_DELAY);
  // The armed button must still be the only one held for repeat to continue.
  assign w_hold_keep = r_armed & (r_dir_up ? w_alone_up : w_alone_dn);

  // ---- next-state and step decisions ----
  always_comb begin
    w_state_nxt = r_state;
    w_in_adj    = (r_state != S_RUN);
    w_arm_up    = 1'b0;
    w_arm_dn    = 1'b0;
    w_rep_fire  = 1'b0;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;

    // MODE wins over a timeout landing in the same cycle.
    if (w_mode_rise) begin
      w_state_nxt = next_field(r_state);
    end else if (w_in_adj && (r_to == TO_LAST)) begin
      w_state_nxt = S_RUN;
    end
    w_state_chg = (w_state_nxt != r_state);

    // No step pulse on a cycle where the field is changing.
    if (w_in_adj && !w_state_chg) begin
      if (w_up_rise && w_alone_up) begin
        w_arm_up  = 1'b1;
        w_step_up = 1'b1;
      end else if (w_dn_rise && w_alone_dn) begin
        w_arm_dn  = 1'b1;
        w_step_dn = 1'b1;
      end else if (w_hold_keep && w_hold_term) begin
        w_rep_fire = 1'b1;
        w_step_up  = r_dir_up;
        w_step_dn  = ~r_dir_up;
      end
    end
  end

  // ---- stage p3: state, counters and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_hold       <= '0;
      r_armed      <= 1'b0;
      r_dir_up     <= 1'b0;
      r_rep        <= 1'b0;
      r_to         <= '0;
      r_blink_cnt  <= '0;
      r_blink      <= 1'b0;
      r_adj_en     <= 6'b0;
      r_adj_active <= 1'b0;
      r_adj_up     <= 1'b0;
      r_adj_down   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_adj_en     <= field_en(w_state_nxt);
      r_adj_active <= (w_state_nxt != S_RUN);
      r_adj_up     <= w_step_up;
      r_adj_down   <= w_step_dn;

      // Hold/repeat tracking: only a fresh, unaccompanied rise arms it;
      // release, a second button or a field change disarms it.
      if (w_state_chg || !w_in_adj) begin
        r_armed <= 1'b0; r_rep <= 1'b0; r_hold <= '0;
      end else if (w_arm_up || w_arm_dn) begin
        r_armed  <= 1'b1;
        r_dir_up <= w_arm_up;
        r_rep    <= 1'b0;
        r_hold   <= HW'(1);
      end else if (w_rep_fire) begin
        r_rep  <= 1'b1;
        r_hold <= HW'(1);
      end else if (w_hold_keep) begin
        r_hold <= r_hold + HW'(1);
      end else begin
        r_armed <= 1'b0; r_rep <= 1'b0; r_hold <= '0;
      end

      // Inactivity timeout: auto-repeat pulses deliberately do not refresh it.
      if (w_any_rise || w_state_chg || !w_in_adj) begin
        r_to <= '0;
      end else begin
        r_to <= sat_inc_to(r_to);
      end

      if (w_state_chg) begin
        r_blink_cnt <= '0;
        r_blink     <= (w_state_nxt != S_RUN);
      end else if (!w_in_adj) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  assign adj_en     = r_adj_en;
  assign adj_up     = r_adj_up;
  assign adj_down   = r_adj_down;
  assign adj_active = r_adj_active;
  assign blink      = r_blink;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
module tb_clock_adjust_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] adj_en;
  logic       adj_up, adj_down, adj_active, blink;

  clock_adjust_ctrl #(
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5),
    .TIMEOUT      (100),
    .BLINK_HALF   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .adj_en    (adj_en),
    .adj_up    (adj_up),
    .adj_down  (adj_down),
    .adj_active(adj_active),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int up_cnt  = 0;
  int dn_cnt  = 0;
  int both_viol = 0;
  int up_q[$];

  typedef struct {
    logic       m, u, d;
    logic [5:0] en;
    logic       act;
    int         ups, dns;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (adj_up) begin up_cnt++; up_q.push_back(cyc); end
    if (adj_down) dn_cnt++;
    if (adj_up && adj_down) both_viol++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    btn_mode = 0; btn_up = 0; btn_down = 0;
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
  endtask

  task automatic mode_press();
    btn_mode = 1; repeat (4) step();
    btn_mode = 0; repeat (4) step();
  endtask

  task automatic clr_counts();
    up_cnt = 0; dn_cnt = 0; up_q.delete();
  endtask

  initial begin
    int exp_off[5];
    int act;
    exp_off = '{0, 20, 25, 30, 35};

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'b000001, 1'b1, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 6'b000001, 1'b1, 1, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 6'b000001, 1'b1, 0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 6'b000010, 1'b1, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 6'b000100, 1'b1, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'b001000, 1'b1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'b001000, 1'b1, 1, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'b010000, 1'b1, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'b100000, 1'b1, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 6'b100000, 1'b1, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 0, 0};

    // Reset state
    repeat (2) step();
    check("reset_outputs", int'({adj_en, adj_up, adj_down, adj_active, blink}), 0);
    rst_n = 1;
    step();
    check("post_reset_outputs", int'({adj_en, adj_up, adj_down, adj_active, blink}), 0);

    // Table: full MODE cycle with single UP/DOWN presses in between
    for (int i = 0; i < 12; i++) begin
      clr_counts();
      btn_mode = vecs[i].m; btn_up = vecs[i].u; btn_down = vecs[i].d;
      repeat (4) step();
      btn_mode = 0; btn_up = 0; btn_down = 0;
      repeat (6) step();
      check($sformatf("vec%0d_en", i), int'(adj_en), int'(vecs[i].en));
      check($sformatf("vec%0d_active", i), int'(adj_active), int'(vecs[i].act));
      check($sformatf("vec%0d_ups", i), up_cnt, vecs[i].ups);
      check($sformatf("vec%0d_dns", i), dn_cnt, vecs[i].dns);
    end

    // Entry timing, blink phase, and UP pulse latency in ADJ_DAY
    do_reset();
    btn_mode = 1;
    repeat (2) step();
    check("entry_not_yet", int'(adj_en), 0);
    step();
    check("entry_en", int'(adj_en), 6'b000001);
    check("entry_blink", int'(blink), 1);
    repeat (2) step();
    check("blink_hold", int'(blink), 1);
    step();
    check("blink_toggle", int'(blink), 0);
    btn_mode = 0; repeat (4) step();
    repeat (3) mode_press();
    check("day_en", int'(adj_en), 6'b001000);
    clr_counts();
    btn_up = 1;
    repeat (2) step();
    check("lat_edge2", int'(adj_up), 0);
    step();
    check("lat_edge3", int'(adj_up), 1);
    step();
    check("lat_edge4", int'(adj_up), 0);
    btn_up = 0; repeat (6) step();
    check("day_single_pulse", up_cnt, 1);

    // Auto-repeat in ADJ_MIN
    do_reset();
    repeat (2) mode_press();
    check("min_en", int'(adj_en), 6'b000010);
    clr_counts();
    btn_up = 1; repeat (40) step();
    btn_up = 0; repeat (20) step();
    check("repeat_count", up_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      act = (i < up_q.size()) ? up_q[i] - up_q[0] : -1;
      check($sformatf("repeat_off%0d", i), act, exp_off[i]);
    end
    check("repeat_no_down", dn_cnt, 0);

    // Both held, then DOWN released with UP still held, then fresh UP press
    clr_counts();
    btn_up = 1; btn_down = 1; repeat (30) step();
    check("both_no_pulse", up_cnt + dn_cnt, 0);
    btn_down = 0; repeat (30) step();
    check("up_after_both_no_pulse", up_cnt + dn_cnt, 0);
    btn_up = 0; repeat (4) step();
    btn_up = 1; repeat (4) step();
    btn_up = 0; repeat (4) step();
    check("fresh_press_pulse", up_cnt, 1);

    // MODE and UP rising together: advance, no step, held UP stays silent
    do_reset();
    mode_press();
    clr_counts();
    btn_mode = 1; btn_up = 1; repeat (4) step();
    btn_mode = 0; repeat (30) step();
    btn_up = 0; repeat (4) step();
    check("mode_up_en", int'(adj_en), 6'b000010);
    check("mode_up_no_pulse", up_cnt, 0);

    // Timeout with no buttons in ADJ_YEAR
    do_reset();
    repeat (5) mode_press();
    btn_mode = 1; repeat (3) step();
    check("year_entry", int'(adj_en), 6'b100000);
    for (int k = 1; k <= 99; k++) begin
      if (k == 2) btn_mode = 0;
      step();
    end
    check("to_99_active", int'(adj_active), 1);
    step();
    check("to_100_active", int'(adj_active), 0);
    check("to_100_en", int'(adj_en), 0);
    check("to_100_blink", int'(blink), 0);

    // Timeout restarted by an UP rise at cycle 60
    do_reset();
    repeat (5) mode_press();
    btn_mode = 1; repeat (3) step();
    check("year_entry2", int'(adj_en), 6'b100000);
    clr_counts();
    for (int k = 1; k <= 159; k++) begin
      if (k == 2) btn_mode = 0;
      if (k == 58) btn_up = 1;
      if (k == 62) btn_up = 0;
      step();
    end
    check("to_press_pulse", up_cnt, 1);
    check("to_159_active", int'(adj_active), 1);
    step();
    check("to_160_active", int'(adj_active), 0);

    // Asynchronous reset mid-repeat in ADJ_HOUR
    do_reset();
    repeat (3) mode_press();
    btn_up = 1; repeat (28) step();
    check("hour_repeat_pulse", int'(adj_up), 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_outputs", int'({adj_en, adj_up, adj_down, adj_active, blink}), 0);
    #1 rst_n = 1;
    clr_counts();
    repeat (40) step();
    check("after_rst_no_pulse", up_cnt, 0);
    check("after_rst_run", int'(adj_en), 0);
    btn_up = 0; repeat (2) step();

    check("never_both_pulses", both_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
